scan_pq: RTL



---
 rtl/scan_pq.sv | 118 +++++++++++
 1 files changed

// File: rtl/scan_pq.sv
// Register-array priority queue: insert-side head tracking plus a sequential rescan after removal.
// Define SCAN_PQ_MAX_PRIORITY_EN to make the largest key the head (default: smallest key).
module scan_pq #(
  parameter int KW    = 8,
  parameter int VW    = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KW+VW-1:0] kvi,
  input  logic             enq,
  input  logic             deq,
  output logic [KW+VW-1:0] kvo,
  output logic             full,
  output logic             empty,
  output logic             busy
);

  localparam int W  = KW + VW;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    slot [DEPTH];
  logic [CW-1:0]   count;
  logic [IW-1:0]   head_idx, scan_i, best_idx, cand_idx, last_idx;
  logic [KW-1:0]   best_key;
  logic [W-1:0]    scan_word;
  logic            idle, acc_enq, acc_deq, acc_rep, scan_take, scan_done;

  function automatic logic better(input logic [KW-1:0] a, input logic [KW-1:0] b);
`ifdef SCAN_PQ_MAX_PRIORITY_EN
    return a > b;
`else
    return a < b;
`endif
  endfunction

  always_comb begin
    idle      = (state == IDLE);
    // enq+deq on an empty queue degrades to a plain enq
    acc_enq   = idle && enq && (!deq || empty) && !full;
    acc_deq   = idle && deq && !enq && !empty;
    acc_rep   = idle && enq && deq && !empty;
    last_idx  = IW'(count - ONE);
    scan_word = slot[scan_i];
    // strict compare keeps the lowest index among equal keys
    scan_take = (scan_i == '0) || better(scan_word[W-1:VW], best_key);
    cand_idx  = scan_take ? scan_i : best_idx;
    scan_done = (state == SCAN) && (CW'(scan_i) == (count - ONE));
    busy      = (state == SCAN);

    state_nxt = state;
    if (acc_rep || (acc_deq && count != ONE)) state_nxt = SCAN;
    if (scan_done)                            state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // array contents need no reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (acc_enq)      slot[IW'(count)] <= kvi;
      else if (acc_deq) slot[head_idx]   <= slot[last_idx];
      else if (acc_rep) slot[head_idx]   <= kvi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      kvo      <= '0;
      head_idx <= '0;
      scan_i   <= '0;
      best_idx <= '0;
      best_key <= '0;
    end else begin
      if (acc_enq) begin
        count <= count + ONE;
        full  <= ((count + ONE) == CW'(DEPTH));
        empty <= 1'b0;
        if (empty || better(kvi[W-1:VW], kvo[W-1:VW])) begin
          head_idx <= IW'(count);
          kvo      <= kvi;
        end
      end
      if (acc_deq) begin
        count  <= count - ONE;
        full   <= 1'b0;
        empty  <= (count == ONE);
        scan_i <= '0;
        if (count == ONE) begin
          kvo      <= '0;
          head_idx <= '0;
        end
      end
      if (acc_rep) scan_i <= '0;
      if (state == SCAN) begin
        scan_i   <= scan_i + 1'b1;
        best_idx <= cand_idx;
        best_key <= scan_take ? scan_word[W-1:VW] : best_key;
        if (scan_done) begin
          head_idx <= cand_idx;
          kvo      <= slot[cand_idx];
        end
      end
    end
  end

endmodule
